sdram_pattern_test: RTL
=======================

Name: sdram_pattern_test

Overview:
- Parametrised SDRAM write/read-back tester. Successor to the fixed incrementing-data tester.
- Sits between the PLL-generated 50 MHz user clock domain and the write/read FIFO ports of the SDRAM controller top.
- Adds selectable data patterns, configurable word count and pass count, per-pass pattern variation, an error counter and a pass counter.

Parameters:
- DATA_W, 16: width of wr_data/rd_data.
- TEST_LEN, 128: words written then read per pass (1..1023).
- PASS_NUM, 0: passes to run; 0 = run forever.
- INIT_WAIT, 100: cycles to wait after sdram_init_done rises before the first write.
- RD_WAIT, 200: cycles between the last write and the first read (controller drains the write FIFO and fills the read FIFO).
- LFSR_TAPS, 16'hB400: Galois LFSR tap mask, DATA_W bits.
- SEED, 16'h0001: LFSR base seed, DATA_W bits, nonzero.

Ports:
- clk_50m  in  1  test clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sdram_init_done  in  1  controller init complete; from the 100 MHz domain, double-flop synchronised internally.
- mode  in  2  pattern: 0 incrementing, 1 walking-one, 2 LFSR, 3 checkerboard.
- wr_en  out  1  write FIFO write enable.
- wr_data  out  DATA_W  write FIFO data.
- rd_en  out  1  read FIFO read enable.
- rd_data  in  DATA_W  read FIFO data; valid exactly one cycle after rd_en.
- error_flag  out  1  sticky; set on the first mismatch.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- pass_cnt  out  16  completed passes, wraps.
- busy  out  1  high in WAIT_INIT through CHECK.
- done  out  1  high in DONE.
- err_addr  out  10  word index of the first mismatch (optional feature).
- err_exp  out  DATA_W  expected data at the first mismatch (optional feature).
- err_act  out  DATA_W  actual data at the first mismatch (optional feature).

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Synchroniser, counters, LFSRs and the mode register cleared; LFSRs load SEED.
- FSM states:
  - IDLE: wait for synced init_done = 1, then go to WAIT_INIT.
  - WAIT_INIT: count INIT_WAIT cycles, then go to WRITE.
  - WRITE: latch mode on entry (first WRITE cycle uses the latched value). Assert wr_en for exactly TEST_LEN consecutive cycles, wr_data = pat(i) for i = 0..TEST_LEN-1, then go to GAP.
  - GAP: count RD_WAIT cycles, then go to READ.
  - READ: assert rd_en for exactly TEST_LEN consecutive cycles, then go to CHECK.
  - CHECK: one cycle; compares the final word.
  - CHECK exit: pass_cnt += 1. If PASS_NUM != 0 and the new pass_cnt == PASS_NUM, go to DONE; else go to WRITE.
  - DONE: terminal; done = 1, wr_en = rd_en = 0. Left only by reset.
- Compare pipeline:
  - The expected word for read index i is registered alongside rd_en.
  - Compare happens the cycle after each rd_en. Exactly TEST_LEN compares per pass; the last compare lands in CHECK.
  - On mismatch: error_flag <= 1, err_cnt += 1 unless already 16'hFFFF.
- Pattern pat(i), p = pass_cnt at pass start, arithmetic modulo 2^DATA_W:
  - Mode 0 (incrementing): i + p.
  - Mode 1 (walking-one): 1 << ((i + p) mod DATA_W).
  - Mode 2 (LFSR):
    - Generator LFSR reloads at WRITE entry with SEED ^ p; if the result is 0, it loads 1.
    - Output value, then advance once per wr_en.
    - Checker LFSR reloads identically at READ entry and advances once per rd_en.
  - Mode 3 (checkerboard): i even gives 0x5555…, i odd gives 0xAAAA… (DATA_W bits); both values inverted when p is odd.
- sdram_init_done deasserted (synced) in any state except DONE:
  - Abort to IDLE; wr_en/rd_en drop the next cycle.
  - err_cnt, error_flag and pass_cnt are kept.
  - An aborted pass is not counted.
- Changes on mode mid-pass are ignored until the next WRITE entry.
- rst_n assertion mid-pass: outputs clear immediately (asynchronous); restart from IDLE.

Optional Feature:
- Macro SDRAM_TEST_ERR_LOG_EN.
- When defined:
  - On the first mismatch since reset (error_flag was 0), capture read index → err_addr, expected → err_exp, actual → err_act.
  - Held until reset; later mismatches do not overwrite.
- When undefined: err_addr/err_exp/err_act are tied to 0 and no capture registers are built.

Test Plan:
- Mode 0, TEST_LEN=8, PASS_NUM=2, ideal FIFO model -> pass 0 writes 0..7, pass 1 writes 1..8; done=1, pass_cnt=2, err_cnt=0, error_flag=0.
- Mode 2, SEED=1, taps 0xB400, model corrupts read word 3 of pass 0 (bit 0 flipped) -> err_cnt=1, error_flag=1; with SDRAM_TEST_ERR_LOG_EN, err_addr=3 and err_exp^err_act=0x0001.
- Mode 1, DATA_W=16, TEST_LEN=20 -> wr_data sequence 0x0001,0x0002,…,0x8000,0x0001…0x0008; every read matches; err_cnt=0.
- Mode 3, pass 1 -> first word 0xAAAA, second 0x5555; model stuck-at-0 data -> err_cnt=20 at TEST_LEN=20.
- sdram_init_done dropped mid-READ of pass 0 -> rd_en low the next cycle, FSM in IDLE, pass_cnt=0; re-raise -> full pass completes after INIT_WAIT.
- rst_n pulsed low during WRITE with err_cnt=5 -> all outputs 0 immediately; restart waits for init_done.

Source files
------------

// File: rtl/sdram_pattern_test.sv
// SDRAM write/read-back pattern tester.
// Writes TEST_LEN words of a selectable pattern into the controller write
// FIFO, waits RD_WAIT cycles, reads them back and counts mismatches. The
// pattern varies with the pass number so stale data from a previous pass
// cannot masquerade as a pass.
//
// Optional build macro: SDRAM_TEST_ERR_LOG_EN
//   Defined   - first mismatch since reset is logged on err_addr/err_exp/err_act.
//   Undefined - those ports are tied to zero.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for synchronised sdram_init_done
// WAIT_INIT  | INIT_WAIT settling cycles before the first write
// WRITE      | wr_en high for TEST_LEN cycles, mode latched on entry
// GAP        | RD_WAIT cycles for the controller to move the data
// READ       | rd_en high for TEST_LEN cycles
// CHECK      | last compare lands here; pass completes on exit
// DONE       | all PASS_NUM passes done; left only by reset
module sdram_pattern_test #(
  parameter int                DATA_W    = 16,
  parameter int                TEST_LEN  = 128,
  parameter int                PASS_NUM  = 0,
  parameter int                INIT_WAIT = 100,
  parameter int                RD_WAIT   = 200,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [DATA_W-1:0] SEED      = 16'h0001
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [1:0]        mode,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              error_flag,
  output logic [15:0]       err_cnt,
  output logic [15:0]       pass_cnt,
  output logic              busy,
  output logic              done,
  output logic [9:0]        err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_act
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_WRITE, S_GAP, S_READ, S_CHECK, S_DONE
  } state_t;

  localparam int TMAX_A = (INIT_WAIT > RD_WAIT) ? INIT_WAIT : RD_WAIT;
  localparam int TMAX   = (TMAX_A > 2) ? TMAX_A : 2;
  localparam int TW     = $clog2(TMAX);
  localparam logic [TW-1:0] INIT_LD = TW'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
  localparam logic [TW-1:0] RD_LD   = TW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [9:0]    LAST    = 10'(TEST_LEN - 1);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  function automatic logic [DATA_W-1:0] pat55_f();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W; k++) v[k] = ((k % 2) == 0);
    return v;
  endfunction

  localparam logic [DATA_W-1:0] PAT_55 = pat55_f();

  // Right-shifting Galois step
  function automatic logic [DATA_W-1:0] lfsr_adv(input logic [DATA_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Per-pass seed; an all-zero LFSR would lock up, so it is replaced by 1
  function automatic logic [DATA_W-1:0] lfsr_seed(input logic [15:0] p);
    logic [DATA_W-1:0] s;
    s = SEED ^ DATA_W'(p);
    return (s == '0) ? ONE : s;
  endfunction

  function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] m, input logic [9:0] i,
                                              input logic [15:0] p,
                                              input logic [DATA_W-1:0] lfsr);
    logic [31:0] sh;
    sh = (32'(i) + 32'(p)) % 32'(DATA_W);
    case (m)
      2'd0:    return DATA_W'(i) + DATA_W'(p);
      2'd1:    return ONE << sh;
      2'd2:    return lfsr;
      default: return (i[0] ? ~PAT_55 : PAT_55) ^ {DATA_W{p[0]}};
    endcase
  endfunction

  logic              init_s1_q, init_s2_q;
  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TW-1:0]     timer_q;
  logic [9:0]        idx_q;
  logic [15:0]       pass_cnt_q, p_next;
  logic              wr_en_q, rd_en_q, busy_q, done_q;
  logic [DATA_W-1:0] wr_data_q, exp_q, gen_lfsr_q, chk_lfsr_q;
  logic [DATA_W-1:0] seed_wr, seed_rd;
  logic              pass_inc, enter_write, enter_read;
  logic              chk_vld_q, error_flag_q, mismatch;
  logic [DATA_W-1:0] chk_exp_q;
  logic [15:0]       err_cnt_q;

  // Two-flop synchroniser for init_done from the controller clock domain
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      init_s1_q <= 1'b0;
      init_s2_q <= 1'b0;
    end else begin
      init_s1_q <= sdram_init_done;
      init_s2_q <= init_s1_q;
    end
  end

  // Next-state and pass-entry decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (init_s2_q) state_d = S_WAIT_INIT;
      S_WAIT_INIT: if (timer_q == '0) state_d = S_WRITE;
      S_WRITE:     if (idx_q == LAST) state_d = S_GAP;
      S_GAP:       if (timer_q == '0) state_d = S_READ;
      S_READ:      if (idx_q == LAST) state_d = S_CHECK;
      S_CHECK:     state_d = ((PASS_NUM != 0) && (pass_cnt_q + 16'd1 == 16'(PASS_NUM)))
                             ? S_DONE : S_WRITE;
      default:     state_d = S_DONE;
    endcase
    if (!init_s2_q && (state_q != S_DONE)) state_d = S_IDLE;

    pass_inc    = (state_q == S_CHECK) && (state_d != S_IDLE);
    p_next      = pass_inc ? pass_cnt_q + 16'd1 : pass_cnt_q;
    enter_write = (state_d == S_WRITE) && (state_q != S_WRITE);
    enter_read  = (state_d == S_READ) && (state_q != S_READ);
    mode_d      = enter_write ? mode : mode_q;
    seed_wr     = lfsr_seed(p_next);
    seed_rd     = lfsr_seed(pass_cnt_q);
  end

  // Sequencer: state, timers, word index, registered outputs, pattern generators.
  // wr_data/exp hold the word for the current cycle and are computed one cycle ahead.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      timer_q    <= '0;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_data_q  <= '0;
      exp_q      <= '0;
      gen_lfsr_q <= SEED;
      chk_lfsr_q <= SEED;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      wr_en_q <= (state_d == S_WRITE);
      rd_en_q <= (state_d == S_READ);
      if (pass_inc) pass_cnt_q <= pass_cnt_q + 16'd1;

      if ((state_d == S_WAIT_INIT) && (state_q != S_WAIT_INIT)) timer_q <= INIT_LD;
      else if ((state_d == S_GAP) && (state_q != S_GAP))        timer_q <= RD_LD;
      else if (timer_q != '0)                                   timer_q <= timer_q - 1'b1;

      if (enter_write || enter_read) idx_q <= '0;
      else if ((state_q == S_WRITE) || (state_q == S_READ)) idx_q <= idx_q + 10'd1;

      if (enter_write) begin
        wr_data_q  <= pat_f(mode_d, 10'd0, p_next, seed_wr);
        gen_lfsr_q <= lfsr_adv(seed_wr);
      end else if (state_q == S_WRITE) begin
        wr_data_q  <= pat_f(mode_q, idx_q + 10'd1, pass_cnt_q, gen_lfsr_q);
        gen_lfsr_q <= lfsr_adv(gen_lfsr_q);
      end

      if (enter_read) begin
        exp_q      <= pat_f(mode_q, 10'd0, pass_cnt_q, seed_rd);
        chk_lfsr_q <= lfsr_adv(seed_rd);
      end else if (state_q == S_READ) begin
        exp_q      <= pat_f(mode_q, idx_q + 10'd1, pass_cnt_q, chk_lfsr_q);
        chk_lfsr_q <= lfsr_adv(chk_lfsr_q);
      end
    end
  end

  assign mismatch = chk_vld_q && (rd_data != chk_exp_q);

  // Compare stage: read data arrives one cycle after rd_en
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q    <= 1'b0;
      chk_exp_q    <= '0;
      error_flag_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      chk_vld_q <= rd_en_q;
      chk_exp_q <= exp_q;
      if (mismatch) begin
        error_flag_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

`ifdef SDRAM_TEST_ERR_LOG_EN
  logic [9:0]        chk_idx_q, err_addr_q;
  logic [DATA_W-1:0] err_exp_q, err_act_q;

  // First-mismatch capture; later mismatches leave the log alone
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      chk_idx_q  <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else begin
      chk_idx_q <= idx_q;
      if (mismatch && !error_flag_q) begin
        err_addr_q <= chk_idx_q;
        err_exp_q  <= chk_exp_q;
        err_act_q  <= rd_data;
      end
    end
  end

  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_act  = err_act_q;
`else
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_act  = '0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign rd_en      = rd_en_q;
  assign error_flag = error_flag_q;
  assign err_cnt    = err_cnt_q;
  assign pass_cnt   = pass_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
